// File: rtl/wb_host_sequencer.sv
// Wishbone classic initiator: queues host commands, runs one single-beat cycle at a time, returns in-order responses.
// Latency: cyc one cycle after accept; backpressure via cmd_ready (FIFO full) and rsp_ready (holds RESP).

module wb_seq_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end
endmodule

module wb_host_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [ADR_WIDTH-1:0]  cmd_adr,
  input  logic [DATA_WIDTH-1:0] cmd_dat,
  input  logic [3:0]            cmd_sel,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_dat,
  output logic                  rsp_err,
  output logic                  wbm_cyc_o,
  output logic                  wbm_stb_o,
  output logic                  wbm_we_o,
  output logic [3:0]            wbm_sel_o,
  output logic [ADR_WIDTH-1:0]  wbm_adr_o,
  output logic [DATA_WIDTH-1:0] wbm_dat_o,
  input  logic                  wbm_ack_i,
  input  logic [DATA_WIDTH-1:0] wbm_dat_i,
  output logic                  busy
);
  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int PW = 1 + 4 + ADR_WIDTH + DATA_WIDTH;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  cyc_q, cyc_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [ADR_WIDTH-1:0]  adr_q, adr_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_dat_q, rsp_dat_d;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_pop;
  logic [PW-1:0]         fifo_dout;
  logic                  head_we;
  logic [3:0]            head_sel;
  logic [ADR_WIDTH-1:0]  head_adr;
  logic [DATA_WIDTH-1:0] head_dat;

  // Ready depends only on occupancy, so a same-cycle pop never opens a slot early.
  assign cmd_ready = ~fifo_full;

  wb_seq_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .push_i  (cmd_valid & ~fifo_full),
    .din_i   ({cmd_we, cmd_sel, cmd_adr, cmd_dat}),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign {head_we, head_sel, head_adr, head_dat} = fifo_dout;

  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = ~fifo_empty | (state_q != S_IDLE);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    sel_d       = sel_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_dat_d   = rsp_dat_q;
    fifo_pop    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = head_we;
          sel_d    = head_sel;
          adr_d    = head_adr;
          dat_d    = head_dat;
          cyc_d    = 1'b1;
          cnt_d    = '0;
          state_d  = S_BUS;
        end
      end
      S_BUS: begin
        cnt_d = cnt_q + CW'(1);
        // An ack arriving on the final allowed cycle still wins over the timeout.
        if (wbm_ack_i) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = we_q ? '0 : wbm_dat_i;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end else if (cnt_q == LAST_CNT) begin
          cyc_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      sel_q       <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_dat_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      sel_q       <= sel_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_dat_q   <= rsp_dat_d;
    end
  end
endmodule

// File: tb/tb_wb_host_sequencer.sv
// Bench for wb_host_sequencer: scripted and random command streams against a transaction-level model
// with a programmable-latency Wishbone slave.
module tb_wb_host_sequencer;
  localparam int TMO = 15;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic        wbm_ack_i;
  logic [31:0] wbm_dat_i;
  logic        busy;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } xact_t;
  typedef struct {
    xact_t       x;
    logic [31:0] rdat;
    logic        err;
    int          len;
  } exp_t;
  typedef struct {
    logic [31:0] dat;
    logic        err;
  } rsp_t;

  exp_t        exp_q[$];
  rsp_t        got_q[$];
  xact_t       obs_q[$];
  int          len_q[$];
  int          dly_q[$];
  logic [31:0] rd_mem [64];
  int          checks = 0;
  int          errors = 0;
  bit          unstable = 0;
  bit          rnd_rdy = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  wb_host_sequencer #(
    .DATA_WIDTH (32),
    .ADR_WIDTH  (32),
    .FIFO_DEPTH (4),
    .TIMEOUT    (TMO)
  ) dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_dat   (cmd_dat),
    .cmd_sel   (cmd_sel),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .wbm_cyc_o (wbm_cyc_o),
    .wbm_stb_o (wbm_stb_o),
    .wbm_we_o  (wbm_we_o),
    .wbm_sel_o (wbm_sel_o),
    .wbm_adr_o (wbm_adr_o),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_i (wbm_ack_i),
    .wbm_dat_i (wbm_dat_i),
    .busy      (busy)
  );

  // Slave + bus monitor: acks each cycle after its programmed delay (-1 = never), random stray acks when idle.
  initial begin : slave
    int    k;
    int    d;
    xact_t snap;
    k = 0;
    d = -1;
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wbm_stb_o !== wbm_cyc_o) unstable = 1;
      if (wbm_cyc_o === 1'b1) begin
        if (k == 0) begin
          snap.we  = wbm_we_o;
          snap.adr = wbm_adr_o;
          snap.dat = wbm_dat_o;
          snap.sel = wbm_sel_o;
          obs_q.push_back(snap);
          d = -1;
          if (dly_q.size() > 0) d = dly_q.pop_front();
        end else if (wbm_we_o !== snap.we || wbm_adr_o !== snap.adr ||
                     wbm_dat_o !== snap.dat || wbm_sel_o !== snap.sel) begin
          unstable = 1;
        end
        wbm_ack_i = (k == d);
        wbm_dat_i = (k == d) ? rd_mem[wbm_adr_o[5:0]] : $urandom;
        k++;
      end else begin
        if (k > 0) len_q.push_back(k);
        k = 0;
        wbm_ack_i = 1'($urandom_range(0, 1));
        wbm_dat_i = $urandom;
      end
    end
  end

  initial begin : collector
    rsp_t r;
    forever begin
      @(negedge wb_clk_i);
      if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
        r.dat = rsp_dat;
        r.err = rsp_err;
        got_q.push_back(r);
      end
    end
  end

  initial begin : rdy_randomizer
    forever begin
      @(posedge wb_clk_i);
      #2;
      if (rnd_rdy) rsp_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic step();
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic clear_model();
    exp_q.delete();
    got_q.delete();
    obs_q.delete();
    len_q.delete();
    dly_q.delete();
    unstable = 0;
  endtask

  task automatic push_cmd(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int d);
    int   n;
    exp_t e;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    while (cmd_ready !== 1'b1 && n < 400) begin
      step();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL push_accept cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
    end else begin
      e.x.we  = we;
      e.x.adr = adr;
      e.x.dat = dat;
      e.x.sel = sel;
      e.err   = (d < 0 || d >= TMO);
      e.len   = e.err ? TMO : d + 1;
      e.rdat  = (e.err || we) ? 32'd0 : rd_mem[adr[5:0]];
      exp_q.push_back(e);
      dly_q.push_back(d);
      step();
      cmd_valid = 1'b0;
    end
  endtask

  task automatic settle(input string name);
    int    n;
    exp_t  e;
    xact_t o;
    rsp_t  g;
    int    l;
    rnd_rdy = 0;
    rsp_ready = 1'b1;
    n = 0;
    while ((got_q.size() < exp_q.size() || busy !== 1'b0) && n < 3000) begin
      step();
      n++;
    end
    step();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s rsp_count got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++;
        $display("FAIL %s bus_xact missing, required adr=%h", name, e.x.adr);
      end else begin
        o = obs_q.pop_front();
        if (o.we !== e.x.we || o.adr !== e.x.adr || o.dat !== e.x.dat || o.sel !== e.x.sel) begin
          errors++;
          $display("FAIL %s bus_xact got we=%b adr=%h dat=%h sel=%h required we=%b adr=%h dat=%h sel=%h",
                   name, o.we, o.adr, o.dat, o.sel, e.x.we, e.x.adr, e.x.dat, e.x.sel);
        end
      end
      checks++;
      l = (len_q.size() > 0) ? len_q.pop_front() : -1;
      if (l != e.len) begin
        errors++;
        $display("FAIL %s cyc_len got %0d required %0d (adr=%h)", name, l, e.len, e.x.adr);
      end
      checks++;
      if (got_q.size() == 0) begin
        errors++;
        $display("FAIL %s rsp missing, required dat=%h err=%b", name, e.rdat, e.err);
      end else begin
        g = got_q.pop_front();
        if (g.dat !== e.rdat || g.err !== e.err) begin
          errors++;
          $display("FAIL %s rsp got dat=%h err=%b required dat=%h err=%b", name, g.dat, g.err, e.rdat, e.err);
        end
      end
    end
    checks++;
    if (unstable) begin
      errors++;
      $display("FAIL %s bus_stability got unstable=1 required 0", name);
    end
    clear_model();
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1;
    repeat (3) step();
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cyc=%b stb=%b we=%b sel=%h adr=%h dat=%h rv=%b rd=%h re=%b busy=%b required all 0",
               wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o, rsp_valid, rsp_dat, rsp_err, busy);
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_cmd_ready got %b required 1", cmd_ready);
    end
    wb_rst_i = 1'b0;
    step();
    clear_model();
  endtask

  task automatic test_write();
    rsp_ready = 1'b1;
    push_cmd(1'b1, 32'd0, 32'd10, 4'hF, 2);
    checks++;
    if (wbm_cyc_o !== 1'b0) begin
      errors++;
      $display("FAIL write_latency_accept_edge cyc=%b required 0", wbm_cyc_o);
    end
    step();
    checks++;
    if (wbm_cyc_o !== 1'b1 || wbm_we_o !== 1'b1 || wbm_dat_o !== 32'd10) begin
      errors++;
      $display("FAIL write_start got cyc=%b we=%b dat=%h required 1 1 0000000a", wbm_cyc_o, wbm_we_o, wbm_dat_o);
    end
    settle("write");
  endtask

  task automatic test_read();
    rd_mem[50] = 32'd30;
    rd_mem[51] = 32'd40;
    rd_mem[52] = 32'd50;
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++)
      push_cmd(1'b0, 32'd50 + 32'(i), $urandom, 4'hF, $urandom_range(0, 3));
    settle("read");
  endtask

  task automatic test_fifo_full();
    rsp_ready = 1'b1;
    push_cmd(1'b1, $urandom, $urandom, 4'h3, 12);
    for (int i = 0; i < 4; i++)
      push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), $urandom_range(0, 4));
    checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full got cmd_ready=%b busy=%b required 0 1", cmd_ready, busy);
    end
    push_cmd(1'b0, $urandom, $urandom, 4'hC, 1);
    settle("fifo_full");
  endtask

  task automatic test_timeout();
    rsp_ready = 1'b1;
    push_cmd(1'b0, $urandom, $urandom, 4'hF, -1);
    push_cmd(1'b1, $urandom, $urandom, 4'hF, 1);
    push_cmd(1'b0, $urandom, $urandom, 4'hF, TMO - 1);
    push_cmd(1'b0, $urandom, $urandom, 4'hF, TMO);
    push_cmd(1'b0, $urandom, $urandom, 4'hF, 0);
    settle("timeout");
  endtask

  task automatic test_rsp_hold();
    int          n;
    logic [31:0] sd;
    logic        se;
    rsp_ready = 1'b0;
    push_cmd(1'b0, $urandom, $urandom, 4'hF, 1);
    push_cmd(1'b1, $urandom, $urandom, 4'hF, 0);
    push_cmd(1'b0, $urandom, $urandom, 4'hF, 0);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_rsp_valid got %b required 1", rsp_valid);
    end
    sd = rsp_dat;
    se = rsp_err;
    for (int i = 0; i < 10; i++) begin
      step();
      checks++;
      if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b1 || rsp_dat !== sd || rsp_err !== se) begin
        errors++;
        $display("FAIL hold_stable cycle %0d got cyc=%b rv=%b dat=%h err=%b required 0 1 %h %b",
                 i, wbm_cyc_o, rsp_valid, rsp_dat, rsp_err, sd, se);
      end
    end
    rsp_ready = 1'b1;
    step();
    checks++;
    if (wbm_cyc_o !== 1'b0 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release_edge got cyc=%b rv=%b required 0 0", wbm_cyc_o, rsp_valid);
    end
    step();
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL hold_next_start got cyc=%b required 1", wbm_cyc_o);
    end
    settle("rsp_hold");
  endtask

  task automatic test_random();
    int dl [10];
    dl = '{0, 1, 2, 3, 5, 13, 14, 15, 20, -1};
    rnd_rdy = 1;
    for (int i = 0; i < 16; i++) begin
      repeat ($urandom_range(0, 2)) step();
      push_cmd(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom), dl[$urandom_range(0, 9)]);
    end
    settle("random");
  endtask

  task automatic test_reset_mid();
    bit saw;
    rsp_ready = 1'b1;
    push_cmd(1'b0, $urandom, $urandom, 4'hF, -1);
    for (int i = 0; i < 3; i++) push_cmd(1'b1, $urandom, $urandom, 4'hF, 0);
    checks++;
    if (wbm_cyc_o !== 1'b1) begin
      errors++;
      $display("FAIL midreset_precondition cyc=%b required 1", wbm_cyc_o);
    end
    wb_rst_i = 1'b1;
    step();
    checks++;
    if (wbm_cyc_o !== 1'b0 || wbm_stb_o !== 1'b0 || busy !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_edge got cyc=%b stb=%b busy=%b rv=%b rdy=%b required 0 0 0 0 1",
               wbm_cyc_o, wbm_stb_o, busy, rsp_valid, cmd_ready);
    end
    wb_rst_i = 1'b0;
    saw = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0 || busy !== 1'b0) saw = 1;
      if (i == 2) clear_model();
    end
    checks++;
    if (saw || got_q.size() != 0) begin
      errors++;
      $display("FAIL midreset_quiet got activity=%b responses=%0d required 0 0", saw, got_q.size());
    end
    clear_model();
    push_cmd(1'b0, $urandom, $urandom, 4'hF, 2);
    settle("after_reset");
  endtask

  initial begin
    wb_rst_i  = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    cmd_sel   = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 64; i++) rd_mem[i] = $urandom;
    test_reset();
    test_write();
    test_read();
    test_fifo_full();
    test_timeout();
    test_rsp_hold();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
